// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
//
// Purpose:
//   Turns a raster-order pixel stream into a sliding 3x3 neighbourhood for a
//   downstream 3x3 filter. Two line buffers keep the previous two image rows.
//   The window shifts left on every accepted pixel. A one-cycle strobe marks
//   each complete, non-border window. The block only moves data; it does no
//   arithmetic on pixel values.
//
// Parameters:
//   DATA_WIDTH  pixel width in bits
//   IMG_WIDTH   pixels per line (>= 3)
//   IMG_HEIGHT  lines per frame (>= 3)
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset; wins over every other input
//   pixel_in      raster-order pixel (left-to-right, top-to-bottom)
//   pixel_valid   pixel_in is accepted on every rising edge where this is high
//   frame_start   qualified by pixel_valid; the accepted pixel becomes (0,0)
//   w1..w9        registered window, row-major: w1 top-left (oldest),
//                 w5 centre, w9 bottom-right (newest)
//   window_valid  one-cycle strobe: w1..w9 hold a complete new window
//   frame_done    (only with WINDOW_3X3_GEN_EOF_EN) high together with
//                 window_valid for the window ending at the last pixel of
//                 the frame
//
// Build option:
//   WINDOW_3X3_GEN_EOF_EN  adds the frame_done output and its logic.
// -----------------------------------------------------------------------------
module window_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] w1,
  output logic [DATA_WIDTH-1:0] w2,
  output logic [DATA_WIDTH-1:0] w3,
  output logic [DATA_WIDTH-1:0] w4,
  output logic [DATA_WIDTH-1:0] w5,
  output logic [DATA_WIDTH-1:0] w6,
  output logic [DATA_WIDTH-1:0] w7,
  output logic [DATA_WIDTH-1:0] w8,
  output logic [DATA_WIDTH-1:0] w9,
  output logic                  window_valid
`ifdef WINDOW_3X3_GEN_EOF_EN
  ,
  output logic                  frame_done
`endif
);

  // ---------------------------------------------------------------------------
  // Local types and constants
  // ---------------------------------------------------------------------------
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pixel_t        win_q [9];
  pixel_t        win_d [9];
  logic          window_valid_q, window_valid_d;

  // Line buffers: l0_mem holds row-1 and l1_mem holds row-2, both indexed by
  // column.
  pixel_t        l0_mem [IMG_WIDTH];
  pixel_t        l1_mem [IMG_WIDTH];

  // ---------------------------------------------------------------------------
  // Accept qualification and effective position
  // ---------------------------------------------------------------------------
  // Reset wins over pixel_valid, so a pixel offered during reset is dropped.
  // It moves neither the counters nor the line buffers.
  logic          accept;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  pixel_t        top_px;
  pixel_t        mid_px;

  assign accept = pixel_valid & ~rst;

  // frame_start forces this pixel to (0,0). The forced position also selects
  // the line-buffer column, so the new frame overwrites column 0.
  assign col_eff = frame_start ? '0 : col_q;
  assign row_eff = frame_start ? '0 : row_q;

  assign top_px = l1_mem[col_eff];
  assign mid_px = l0_mem[col_eff];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so that no path leaves one
    // unassigned; an unassigned path would infer a latch.
    col_d          = col_q;
    row_d          = row_q;
    win_d          = win_q;
    window_valid_d = 1'b0;

    if (accept) begin
      // Raster counters: the column wraps into the next row, and the last
      // pixel of the frame wraps both counters back to (0,0).
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end

      // Shift every window row left; the new column enters on the right.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top_px;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid_px;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pixel_in;

      // Border positions still shift but do not produce a window. This gating
      // also keeps stale line-buffer data out of every window marked valid.
      window_valid_d = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge, whatever the statement order.
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      win_q          <= '{default: '0};
      window_valid_q <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      win_q          <= win_d;
      window_valid_q <= window_valid_d;
    end
  end

  // NOTE: the line buffers are deliberately not reset. A reset loop over a
  // memory would stop it mapping to RAM, and stale contents never reach a
  // window marked valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      l1_mem[col_eff] <= mid_px;
      l0_mem[col_eff] <= pixel_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional end-of-frame marker
  // ---------------------------------------------------------------------------
`ifdef WINDOW_3X3_GEN_EOF_EN
  logic frame_done_q, frame_done_d;

  // The last pixel of a frame always completes a valid window (the size is at
  // least 3x3), so this marker coincides with that window's strobe.
  always_comb begin
    frame_done_d = accept && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w1           = win_q[0];
  assign w2           = win_q[1];
  assign w3           = win_q[2];
  assign w4           = win_q[3];
  assign w5           = win_q[4];
  assign w6           = win_q[5];
  assign w7           = win_q[6];
  assign w8           = win_q[7];
  assign w9           = win_q[8];
  assign window_valid = window_valid_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_gen
//
// Self-checking bench for window_3x3_gen on a 4x4 image with 8-bit pixels.
// A reference model stores every driven pixel at its raster position. For each
// accepted pixel at row>=2, col>=2 it builds the expected window straight from
// the stored image and queues it. A negedge monitor pops one entry per
// window_valid strobe and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [9*DW-1:0] win;
    logic            fd;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pixel_in;
  logic          pixel_valid;
  logic          frame_start;
  logic [DW-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic          window_valid;
`ifdef WINDOW_3X3_GEN_EOF_EN
  logic          frame_done;
`endif

  window_3x3_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .w1           (w1),
    .w2           (w2),
    .w3           (w3),
    .w4           (w4),
    .w5           (w5),
    .w6           (w6),
    .w7           (w7),
    .w8           (w8),
    .w9           (w9),
    .window_valid (window_valid)
`ifdef WINDOW_3X3_GEN_EOF_EN
    ,
    .frame_done   (frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9*DW-1:0] win_obs;
  assign win_obs = {w1, w2, w3, w4, w5, w6, w7, w8, w9};

  int n_cmp  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  exp_t            sb_q[$];
  logic [DW-1:0]   img [H][W];
  int              m_row = 0;
  int              m_col = 0;
  logic [9*DW-1:0] last_exp = '0;

  task automatic check(input string tag, input logic [9*DW-1:0] obs,
                       input logic [9*DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued window.
  always @(negedge clk) begin
    if (window_valid === 1'b1) begin
      strobe_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 72'd1, 72'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        last_exp = e.win;
        check("window", win_obs, e.win);
`ifdef WINDOW_3X3_GEN_EOF_EN
        check("frame_done", 72'(frame_done), 72'(e.fd));
`endif
      end
    end else begin
`ifdef WINDOW_3X3_GEN_EOF_EN
      check("frame_done_idle", 72'(frame_done), 72'd0);
`endif
    end
  end

  // Drives one accepted pixel and records its expectation in the model.
  task automatic drive_pixel(input logic [DW-1:0] p, input bit fs);
    int r, c;
    r = fs ? 0 : m_row;
    c = fs ? 0 : m_col;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      exp_t e;
      e.win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
               img[r-1][c-2], img[r-1][c-1], img[r-1][c],
               img[r][c-2],   img[r][c-1],   img[r][c]};
      e.fd  = (r == H-1) && (c == W-1);
      sb_q.push_back(e);
    end
    if (c == W-1) begin
      m_col = 0;
      m_row = (r == H-1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
    pixel_in    = p;
    pixel_valid = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Synchronous reset with a competing pixel/frame_start that must be ignored.
  task automatic do_reset();
    rst         = 1'b1;
    pixel_in    = 8'd99;
    pixel_valid = 1'b1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    check("reset_window", win_obs, '0);
    check("reset_valid", 72'(window_valid), 72'd0);
    rst         = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic frame_seq(input int base, input bit fs_first);
    for (int i = 0; i < W*H; i++) begin
      drive_pixel(8'(base + i), fs_first && (i == 0));
    end
  endtask

  initial begin
    rst = 1'b0;
    pixel_in = '0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // Continuous frame 1..16, with the first window checked literally.
    strobe_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      drive_pixel(8'(i), i == 1);
      if (i == 11) begin
        check("lit_win_p11", win_obs,
              {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      end
    end
    idle(2);
    check("strobes_frame", 72'(strobe_cnt), 72'd4);

    // Same frame with a three-cycle gap after pixel 11: the window holds.
    strobe_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      drive_pixel(8'(i), i == 1);
      if (i == 11) begin
        for (int g = 0; g < 3; g++) begin
          @(posedge clk);
          #1;
          check("gap_valid_low", 72'(window_valid), 72'd0);
          check("gap_hold",      win_obs,
                {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
        end
      end
      if (i == 12) begin
        check("lit_win_p12", win_obs,
              {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12});
      end
    end
    idle(2);
    check("strobes_gap", 72'(strobe_cnt), 72'd4);

    // Back-to-back frames; the second frame has no frame_start.
    strobe_cnt = 0;
    frame_seq(1, 1'b1);
    for (int i = 17; i <= 32; i++) begin
      drive_pixel(8'(i), 1'b0);
      if (i == 27) begin
        check("lit_win_p27", win_obs,
              {8'd17, 8'd18, 8'd19, 8'd21, 8'd22, 8'd23, 8'd25, 8'd26, 8'd27});
      end
    end
    idle(2);
    check("strobes_b2b", 72'(strobe_cnt), 72'd8);

    // Reset mid-frame after pixel 7, then a fresh frame without frame_start.
    strobe_cnt = 0;
    for (int i = 1; i <= 7; i++) drive_pixel(8'(i), i == 1);
    do_reset();
    for (int i = 101; i <= 116; i++) begin
      drive_pixel(8'(i), 1'b0);
      if (i == 111) begin
        check("lit_win_p111", win_obs,
              {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107,
               8'd109, 8'd110, 8'd111});
      end
    end
    idle(2);
    check("strobes_rst", 72'(strobe_cnt), 72'd4);

    // frame_start mid-frame on pixel 6 restarts the raster.
    strobe_cnt = 0;
    for (int i = 1; i <= 5; i++) drive_pixel(8'(i), i == 1);
    for (int i = 6; i <= 21; i++) begin
      drive_pixel(8'(i), i == 6);
      if (i == 16) begin
        check("lit_win_restart", win_obs,
              {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16});
      end
    end
    idle(2);
    check("strobes_restart", 72'(strobe_cnt), 72'd4);

    // Random pixel values with random idle gaps.
    strobe_cnt = 0;
    for (int i = 0; i < W*H; i++) begin
      drive_pixel(8'($urandom_range(0, 255)), i == 0);
      idle($urandom_range(0, 2));
    end
    idle(2);
    check("strobes_random", 72'(strobe_cnt), 72'd4);

    idle(3);
    check("sb_drained", 72'(sb_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line (>=3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (>=3).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pixel_in  input  DATA_WIDTH  raster-order pixel, left-to-right, top-to-bottom.
REQ-007 pixel_valid  input  1  pixel_in accepted on every rising edge where high; no backpressure.
REQ-008 frame_start  input  1  qualified by pixel_valid; marks the accepted pixel as (row 0, col 0).
REQ-009 w1..w9  output  DATA_WIDTH each  registered 3x3 window, row-major; w1 top-left (oldest), w5 centre, w9 bottom-right (newest); drives a 3x3 filter's in1..in9.
REQ-010 window_valid  output  1  one-cycle strobe: w1..w9 hold a complete new window; drives the filter's enable.

Function
REQ-011 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advanced only on accepted pixels.
REQ-012 On accept: col wraps IMG_WIDTH-1 -> 0 with row+1; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
REQ-013 frame_start with pixel_valid SHALL override counters: that pixel is (0,0); next accept is (0,1).
REQ-014 SHALL hold two line buffers, each IMG_WIDTH deep: L0 (row-1) and L1 (row-2), addressed by col.
REQ-015 On accept at col c: top=L1[c], mid=L0[c], bot=pixel_in; L1[c]<=L0[c]; L0[c]<=pixel_in.
REQ-016 On accept, window SHALL shift left: w1<=w2, w2<=w3, w3<=top; w4<=w5, w5<=w6, w6<=mid; w7<=w8, w8<=w9, w9<=bot.
REQ-017 window_valid SHALL be registered: high the cycle after an accept where row>=2 and col>=2, else low.
REQ-018 Latency: one clk from accepted pixel to updated w1..w9 with window_valid.
REQ-019 Border positions (row<2 or col<2) SHALL still shift w1..w9 but produce no window_valid; no padding.
REQ-020 pixel_valid low: w1..w9, counters, line buffers hold; window_valid low.
REQ-021 Windows per frame SHALL be exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2).
REQ-022 Pure data movement; no arithmetic on pixel values.

Reset
REQ-023 rst SHALL clear col, row, w1..w9 to 0 and window_valid to 0 at the next rising edge.
REQ-024 Line buffer contents need not be cleared; stale data never reaches a valid window (REQ-017 gating).
REQ-025 rst mid-frame SHALL abandon the frame; next accepted pixel is (0,0).
REQ-026 rst SHALL take priority over pixel_valid and frame_start in the same cycle.

Configuration
REQ-027 Macro WINDOW_3X3_GEN_EOF_EN SHALL gate output frame_done (1 bit, reset 0).
REQ-028 Defined: frame_done high one cycle, same cycle as window_valid for the window from pixel (IMG_HEIGHT-1, IMG_WIDTH-1); low otherwise.
REQ-029 Undefined: no frame_done port, no related logic; all other behaviour identical.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4 unless stated)
REQ-030 Pixels 1..16 continuous, frame_start on pixel 1 -> after pixel 11: window_valid=1, w1..w9=1,2,3,5,6,7,9,10,11; after 12: 2,3,4,6,7,8,10,11,12; after 15: 5,6,7,9,10,11,13,14,15; after 16: 6,7,8,10,11,12,14,15,16; 4 strobes total; none after 13 or 14.
REQ-031 Same frame, pixel_valid low 3 cycles after pixel 11 -> w1..w9 hold, window_valid low in gap; pixel 12 still yields 2,3,4,6,7,8,10,11,12.
REQ-032 Back-to-back frames 1..16 then 17..32 without frame_start -> second frame's first window 17,18,19,21,22,23,25,26,27; 8 strobes total.
REQ-033 rst one cycle after pixel 7, then fresh frame 101..116 -> no strobe before pixel 111; first window 101,102,103,105,106,107,109,110,111; outputs 0 during reset.
REQ-034 frame_start asserted on pixel 6 mid-frame -> pixel 6 is (0,0); first strobe 10 accepts later.
REQ-035 With WINDOW_3X3_GEN_EOF_EN, pixels 1..16 -> frame_done=1 only with window 6,7,8,10,11,12,14,15,16; without macro, port absent and REQ-030 passes unchanged.
